alu_cmd_controller: RTL

Command sequencer between the UART receiver/transmitter and the ALU in `top`. It decodes bytes from the UART receiver as a command/operand stream, latches operand A, operand B and the ALU opcode, and on an execute command launches one UART transmission of the ALU result. It also exposes its one-hot state on `state_output` for debug and LEDs.

---
 rtl/alu_cmd_controller_if.sv | 38 +++
 rtl/alu_cmd_controller.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/alu_cmd_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_controller_if
// Description : Bus bundle between the command controller and its UART/ALU
//               environment. The master side is the controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_cmd_controller_if #(
    parameter int N    = 8,
    parameter int OP_W = 6
);
    logic [N-1:0]    rx_data;
    logic            rx_done;
    logic [N-1:0]    alu_result;
    logic            tx_done;
    logic [N-1:0]    reg_a;
    logic [N-1:0]    reg_b;
    logic [OP_W-1:0] alu_op;
    logic [N-1:0]    tx_data;
    logic            tx_start;
    logic [N-1:0]    data_out;
    logic [4:0]      state_output;
    logic            cmd_err;
    logic            rx_overrun;

    modport master (
        input  rx_data, rx_done, alu_result, tx_done,
        output reg_a, reg_b, alu_op, tx_data, tx_start, data_out,
               state_output, cmd_err, rx_overrun
    );

    modport slave (
        output rx_data, rx_done, alu_result, tx_done,
        input  reg_a, reg_b, alu_op, tx_data, tx_start, data_out,
               state_output, cmd_err, rx_overrun
    );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_controller.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_controller
// Description : Decodes a UART byte stream into operand/opcode loads and
//               execute commands; launches one UART transmit of the ALU
//               result per execute and reports its one-hot state.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_controller #(
    parameter int             N        = 8,
    parameter int             OP_W     = 6,
    parameter logic [N-1:0]   CMD_A    = 'h01,
    parameter logic [N-1:0]   CMD_B    = 'h02,
    parameter logic [N-1:0]   CMD_OP   = 'h03,
    parameter logic [N-1:0]   CMD_EXEC = 'h04
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_cmd_controller_if.master bus
);

    // One-hot encoding doubles as the debug/LED output.
    typedef enum logic [4:0] {
        IDLE    = 5'b00001,
        WAIT_A  = 5'b00010,
        WAIT_B  = 5'b00100,
        WAIT_OP = 5'b01000,
        SEND    = 5'b10000
    } state_t;

    state_t          r_state,      w_state_nxt;
    logic [N-1:0]    r_reg_a,      w_reg_a_nxt;
    logic [N-1:0]    r_reg_b,      w_reg_b_nxt;
    logic [OP_W-1:0] r_alu_op,     w_alu_op_nxt;
    logic [N-1:0]    r_tx_data,    w_tx_data_nxt;
    logic            r_tx_start,   w_tx_start_nxt;
    logic [N-1:0]    r_data_out,   w_data_out_nxt;
    logic            r_cmd_err,    w_cmd_err_nxt;
    logic            r_rx_overrun, w_rx_overrun_nxt;

    // State and all outputs are registered; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_reg_a      <= '0;
            r_reg_b      <= '0;
            r_alu_op     <= '0;
            r_tx_data    <= '0;
            r_tx_start   <= 1'b0;
            r_data_out   <= '0;
            r_cmd_err    <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_reg_a      <= w_reg_a_nxt;
            r_reg_b      <= w_reg_b_nxt;
            r_alu_op     <= w_alu_op_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_tx_start   <= w_tx_start_nxt;
            r_data_out   <= w_data_out_nxt;
            r_cmd_err    <= w_cmd_err_nxt;
            r_rx_overrun <= w_rx_overrun_nxt;
        end
    end

    // Next-state and next-register decode; pulses default low each cycle.
    always_comb begin
        w_state_nxt      = r_state;
        w_reg_a_nxt      = r_reg_a;
        w_reg_b_nxt      = r_reg_b;
        w_alu_op_nxt     = r_alu_op;
        w_tx_data_nxt    = r_tx_data;
        w_tx_start_nxt   = 1'b0;
        w_data_out_nxt   = r_data_out;
        w_cmd_err_nxt    = 1'b0;
        w_rx_overrun_nxt = r_rx_overrun;

        case (r_state)
            IDLE: begin
                if (bus.rx_done) begin
                    case (bus.rx_data)
                        CMD_A:    w_state_nxt = WAIT_A;
                        CMD_B:    w_state_nxt = WAIT_B;
                        CMD_OP:   w_state_nxt = WAIT_OP;
                        CMD_EXEC: begin
                            // Capture the result now so tx_data is stable
                            // for the whole transmission.
                            w_tx_data_nxt  = bus.alu_result;
                            w_tx_start_nxt = 1'b1;
                            w_state_nxt    = SEND;
                        end
                        default:  w_cmd_err_nxt = 1'b1;
                    endcase
                end
            end
            // The byte after a command is always data, even if it looks
            // like a command code.
            WAIT_A: begin
                if (bus.rx_done) begin
                    w_reg_a_nxt = bus.rx_data;
                    w_state_nxt = IDLE;
                end
            end
            WAIT_B: begin
                if (bus.rx_done) begin
                    w_reg_b_nxt = bus.rx_data;
                    w_state_nxt = IDLE;
                end
            end
            WAIT_OP: begin
                if (bus.rx_done) begin
                    w_alu_op_nxt = bus.rx_data[OP_W-1:0];
                    w_state_nxt  = IDLE;
                end
            end
            SEND: begin
                // Bytes received mid-transmit are lost; flag it until reset.
                if (bus.rx_done) begin
                    w_rx_overrun_nxt = 1'b1;
                end
                if (bus.tx_done) begin
                    w_data_out_nxt = r_tx_data;
                    w_state_nxt    = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.reg_a        = r_reg_a;
    assign bus.reg_b        = r_reg_b;
    assign bus.alu_op       = r_alu_op;
    assign bus.tx_data      = r_tx_data;
    assign bus.tx_start     = r_tx_start;
    assign bus.data_out     = r_data_out;
    assign bus.state_output = r_state;
    assign bus.cmd_err      = r_cmd_err;
    assign bus.rx_overrun   = r_rx_overrun;

endmodule
`default_nettype wire
